// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code tracking path.
package ps2_pkg;

    localparam int unsigned PS2_BYTE_W = 8;

    localparam logic [PS2_BYTE_W-1:0] PS2_EXT = 8'hE0;
    localparam logic [PS2_BYTE_W-1:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_keyboard_lut.sv
// Scan-code set 2 to ASCII lookup (letters lowercase); unmapped codes give 0x00.
module ps2_keyboard_lut
    import ps2_pkg::*;
(
    input  logic [PS2_BYTE_W-1:0] scan_i,
    output logic [PS2_BYTE_W-1:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        case (scan_i)
            8'h1C: ascii_o = 8'h61;  8'h32: ascii_o = 8'h62;
            8'h21: ascii_o = 8'h63;  8'h23: ascii_o = 8'h64;
            8'h24: ascii_o = 8'h65;  8'h2B: ascii_o = 8'h66;
            8'h34: ascii_o = 8'h67;  8'h33: ascii_o = 8'h68;
            8'h43: ascii_o = 8'h69;  8'h3B: ascii_o = 8'h6A;
            8'h42: ascii_o = 8'h6B;  8'h4B: ascii_o = 8'h6C;
            8'h3A: ascii_o = 8'h6D;  8'h31: ascii_o = 8'h6E;
            8'h44: ascii_o = 8'h6F;  8'h4D: ascii_o = 8'h70;
            8'h15: ascii_o = 8'h71;  8'h2D: ascii_o = 8'h72;
            8'h1B: ascii_o = 8'h73;  8'h2C: ascii_o = 8'h74;
            8'h3C: ascii_o = 8'h75;  8'h2A: ascii_o = 8'h76;
            8'h1D: ascii_o = 8'h77;  8'h22: ascii_o = 8'h78;
            8'h35: ascii_o = 8'h79;  8'h1A: ascii_o = 8'h7A;
            8'h45: ascii_o = 8'h30;  8'h16: ascii_o = 8'h31;
            8'h1E: ascii_o = 8'h32;  8'h26: ascii_o = 8'h33;
            8'h25: ascii_o = 8'h34;  8'h2E: ascii_o = 8'h35;
            8'h36: ascii_o = 8'h36;  8'h3D: ascii_o = 8'h37;
            8'h3E: ascii_o = 8'h38;  8'h46: ascii_o = 8'h39;
            8'h29: ascii_o = 8'h20;  8'h5A: ascii_o = 8'h0D;
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes make/break/extended scan-code sequences, tracks the held key and
// counts distinct presses for the seven-segment display stage.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned COUNT_W          = 8,
    parameter bit          SAT_COUNT        = 1'b0,
    parameter bit          BLANK_ON_RELEASE = 1'b1,
    parameter bit          IGNORE_REPEAT    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  clrn_i,
    input  logic [PS2_BYTE_W-1:0] key_data_i,
    input  logic                  key_ready_i,
    input  logic                  key_ovf_i,
    output logic                  key_pop_o,
    output logic [PS2_BYTE_W-1:0] scan_o,
    output logic                  ext_o,
    output logic [PS2_BYTE_W-1:0] ascii_o,
    output logic                  pressed_o,
    output logic [COUNT_W-1:0]    press_cnt_o,
    output logic                  event_o,
    output logic                  blank_o,
    output logic                  err_o
);

    ps2_state_e              state, state_n;
    logic [PS2_BYTE_W-1:0]   scan_n;
    logic                    ext_n;
    logic                    pressed_n;
    logic [COUNT_W-1:0]      cnt_n;
    logic                    event_n;
    logic                    err_n;
    logic                    do_make;
    logic                    do_brk;
    logic                    code_ext;
    logic                    same_key;
    logic [PS2_BYTE_W-1:0]   lut_ascii;

    // Pop whenever a byte is waiting; held low while in reset.
    assign key_pop_o = key_ready_i & clrn_i;

    // Sequence decode and held-key bookkeeping for the consumed byte.
    always_comb begin
        state_n   = state;
        scan_n    = scan_o;
        ext_n     = ext_o;
        pressed_n = pressed_o;
        cnt_n     = press_cnt_o;
        event_n   = 1'b0;
        err_n     = err_o;
        do_make   = 1'b0;
        do_brk    = 1'b0;
        code_ext  = 1'b0;

        if (key_ovf_i) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
        end else if (key_pop_o) begin
            case (state)
                ST_IDLE: begin
                    if (key_data_i == PS2_EXT)      state_n = ST_EXT;
                    else if (key_data_i == PS2_BRK) state_n = ST_BRK;
                    else                            do_make = 1'b1;
                end
                ST_EXT: begin
                    code_ext = 1'b1;
                    if (key_data_i == PS2_EXT)      state_n = ST_EXT;
                    else if (key_data_i == PS2_BRK) state_n = ST_EXT_BRK;
                    else begin
                        do_make = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (key_data_i == PS2_BRK)      state_n = ST_BRK;
                    else if (key_data_i == PS2_EXT) state_n = ST_EXT_BRK;
                    else begin
                        do_brk  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    code_ext = 1'b1;
                    if (key_data_i != PS2_EXT && key_data_i != PS2_BRK) begin
                        do_brk  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        same_key = pressed_o && (scan_o == key_data_i) && (ext_o == code_ext);

        if (do_make && !(same_key && IGNORE_REPEAT)) begin
            scan_n    = key_data_i;
            ext_n     = code_ext;
            pressed_n = 1'b1;
            event_n   = 1'b1;
            if (!(SAT_COUNT && (&press_cnt_o))) cnt_n = press_cnt_o + COUNT_W'(1);
        end

        if (do_brk && same_key) pressed_n = 1'b0;
    end

    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            state       <= ST_IDLE;
            scan_o      <= '0;
            ext_o       <= 1'b0;
            pressed_o   <= 1'b0;
            press_cnt_o <= '0;
            event_o     <= 1'b0;
            err_o       <= 1'b0;
            blank_o     <= BLANK_ON_RELEASE;
        end else begin
            state       <= state_n;
            scan_o      <= scan_n;
            ext_o       <= ext_n;
            pressed_o   <= pressed_n;
            press_cnt_o <= cnt_n;
            event_o     <= event_n;
            err_o       <= err_n;
            blank_o     <= BLANK_ON_RELEASE & ~pressed_n;
        end
    end

    ps2_keyboard_lut u_lut (
        .scan_i  (scan_o),
        .ascii_o (lut_ascii)
    );

    // Extended keys have no ASCII meaning on this display.
    assign ascii_o = ext_o ? 8'h00 : lut_ascii;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboarded bench: default tracker plus a 2-bit saturating, repeat-counting variant.
module tb_ps2_key_tracker;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] key_data = 8'h00;
    logic       key_ready = 1'b0;
    logic       key_ovf = 1'b0;

    logic       pop, ext, pressed, evt, blank, err;
    logic [7:0] scan, ascii, cnt;
    logic       pop_a, ext_a, pressed_a, evt_a, blank_a, err_a;
    logic [7:0] scan_a, ascii_a;
    logic [1:0] cnt_a;

    typedef struct {
        logic [7:0] scan;
        logic       ext;
        logic [7:0] ascii;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   alt_events = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    ps2_key_tracker u_dut (
        .clk_i(clk), .clrn_i(rst_n), .key_data_i(key_data), .key_ready_i(key_ready),
        .key_ovf_i(key_ovf), .key_pop_o(pop), .scan_o(scan), .ext_o(ext),
        .ascii_o(ascii), .pressed_o(pressed), .press_cnt_o(cnt), .event_o(evt),
        .blank_o(blank), .err_o(err)
    );

    ps2_key_tracker #(.COUNT_W(2), .SAT_COUNT(1'b1), .BLANK_ON_RELEASE(1'b0),
                      .IGNORE_REPEAT(1'b0)) u_alt (
        .clk_i(clk), .clrn_i(rst_n), .key_data_i(key_data), .key_ready_i(key_ready),
        .key_ovf_i(key_ovf), .key_pop_o(pop_a), .scan_o(scan_a), .ext_o(ext_a),
        .ascii_o(ascii_a), .pressed_o(pressed_a), .press_cnt_o(cnt_a), .event_o(evt_a),
        .blank_o(blank_a), .err_o(err_a)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    task automatic send(input logic [7:0] b);
        key_data  = b;
        key_ready = 1'b1;
        @(posedge clk);
        #1 key_ready = 1'b0;
    endtask

    // Queue the expected event for a counted press, then issue its final byte.
    task automatic press(input logic [7:0] code, input logic e, input logic [7:0] asc);
        exp_t x;
        exp_cnt = exp_cnt + 8'd1;
        x.scan = code; x.ext = e; x.ascii = asc; x.cnt = exp_cnt;
        sb.push_back(x);
        if (e) send(PS2_EXT);
        send(code);
    endtask

    task automatic pulse_ovf();
        key_ovf = 1'b1;
        @(posedge clk);
        #1 key_ovf = 1'b0;
    endtask

    // Event monitor: each pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_event", {24'd0, scan}, 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("ev_scan", {24'd0, scan}, {24'd0, x.scan});
                chk("ev_ext", {31'd0, ext}, {31'd0, x.ext});
                chk("ev_ascii", {24'd0, ascii}, {24'd0, x.ascii});
                chk("ev_cnt", {24'd0, cnt}, {24'd0, x.cnt});
                chk("ev_pressed", {31'd0, pressed}, 32'd1);
            end
        end
        if (rst_n === 1'b1 && evt_a === 1'b1) alt_events++;
    end

    initial begin
        // Asynchronous reset, checked before the first clock edge.
        key_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pop", {31'd0, pop}, 32'd0);
        chk("rst_scan", {24'd0, scan}, 32'h00);
        chk("rst_ext", {31'd0, ext}, 32'd0);
        chk("rst_pressed", {31'd0, pressed}, 32'd0);
        chk("rst_cnt", {24'd0, cnt}, 32'd0);
        chk("rst_event", {31'd0, evt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_blank", {31'd0, blank}, 32'd1);
        chk("rst_blank_alt", {31'd0, blank_a}, 32'd0);
        key_ready = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain make then break of 'a'.
        press(8'h1C, 1'b0, 8'h61);
        chk("a_pressed", {31'd0, pressed}, 32'd1);
        chk("a_blank", {31'd0, blank}, 32'd0);
        send(PS2_BRK); send(8'h1C);
        chk("a_released", {31'd0, pressed}, 32'd0);
        chk("a_blank_rel", {31'd0, blank}, 32'd1);
        chk("a_scan_kept", {24'd0, scan}, 32'h1C);
        chk("alt_blank_rel", {31'd0, blank_a}, 32'd0);

        // Typematic repeat: counted once here, three times on the variant.
        press(8'h1C, 1'b0, 8'h61);
        send(8'h1C); send(8'h1C);
        send(PS2_BRK); send(8'h1C);
        chk("rep_cnt", {24'd0, cnt}, 32'd2);
        chk("alt_sat_cnt", {30'd0, cnt_a}, 32'd3);
        @(negedge clk);
        chk("alt_events_rep", alt_events, 32'd4);
        @(posedge clk); #1;

        // Extended key: plain break ignored, extended break releases.
        press(8'h75, 1'b1, 8'h00);
        chk("ext_flag", {31'd0, ext}, 32'd1);
        chk("ext_ascii", {24'd0, ascii}, 32'h00);
        send(PS2_BRK); send(8'h75);
        chk("ext_plain_brk", {31'd0, pressed}, 32'd1);
        send(PS2_EXT); send(PS2_BRK); send(8'h75);
        chk("ext_brk", {31'd0, pressed}, 32'd0);
        chk("ext_kept", {31'd0, ext}, 32'd1);

        // Rollover to a second key; break of the old key is ignored.
        press(8'h1C, 1'b0, 8'h61);
        press(8'h32, 1'b0, 8'h62);
        send(PS2_BRK); send(8'h1C);
        chk("roll_pressed", {31'd0, pressed}, 32'd1);
        chk("roll_scan", {24'd0, scan}, 32'h32);
        chk("roll_cnt", {24'd0, cnt}, 32'd5);
        send(PS2_BRK); send(8'h32);
        chk("roll_rel", {31'd0, pressed}, 32'd0);

        // Overflow discards a pending prefix and a byte consumed alongside it.
        send(PS2_EXT);
        pulse_ovf();
        chk("ovf_err", {31'd0, err}, 32'd1);
        press(8'h1C, 1'b0, 8'h61);
        chk("ovf_plain", {31'd0, ext}, 32'd0);
        key_data = 8'h32; key_ready = 1'b1; key_ovf = 1'b1;
        @(posedge clk);
        #1 begin key_ready = 1'b0; key_ovf = 1'b0; end
        chk("ovf_drop_scan", {24'd0, scan}, 32'h1C);
        chk("ovf_drop_cnt", {24'd0, cnt}, 32'd6);
        send(PS2_BRK); send(8'h1C);
        chk("ovf_sticky", {31'd0, err}, 32'd1);

        // 250 more presses carry the 8-bit counter past all-ones to zero.
        for (int i = 0; i < 250; i++) begin
            press(8'h1C, 1'b0, 8'h61);
            send(PS2_BRK); send(8'h1C);
        end
        chk("wrap_cnt", {24'd0, cnt}, 32'd0);
        chk("alt_sat_hold", {30'd0, cnt_a}, 32'd3);
        @(negedge clk);
        chk("alt_events_all", alt_events, 32'd258);
        @(posedge clk); #1;

        // Reset in the middle of an extended sequence.
        press(8'h1C, 1'b0, 8'h61);
        send(PS2_EXT);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_scan", {24'd0, scan}, 32'h00);
        chk("mid_rst_pressed", {31'd0, pressed}, 32'd0);
        chk("mid_rst_cnt", {24'd0, cnt}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_cnt = 8'd0;
        press(8'h1C, 1'b0, 8'h61);
        chk("post_rst_ext", {31'd0, ext}, 32'd0);
        chk("post_rst_cnt", {24'd0, cnt}, 32'd1);

        repeat (3) @(posedge clk);
        #1 chk("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
